// File: rtl/operand_select_pkg.sv
// Shared definitions for the operand selector: default sizes, a ceil-log2 helper
// and the beat record carried through the output pipeline.
package operand_select_pkg;

    localparam int unsigned DEF_WIDTH  = 64;
    localparam int unsigned DEF_NUM_IN = 2;

    // ceil(log2(v)), never below 1 so a select port always has at least one bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 sel_err;
    } beat_t;

endpackage

// File: rtl/operand_select_pipe_if.sv
// Handshake bundle between the operand producer, the selector and its consumer.
interface operand_select_pipe_if
    import operand_select_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NUM_IN = DEF_NUM_IN
);
    localparam int unsigned SEL_W = clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );

endinterface

// File: rtl/operand_select_pipe_skid_buffer.sv
// Two-entry pipeline register: output stage O plus skid stage S.
// in_ready comes straight from a flop (!S.valid), so upstream never sees a
// combinational path from out_ready.
module skid_buffer #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_payload,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_payload,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] o_data;
    logic         o_valid;
    logic [W-1:0] s_data;
    logic         s_valid;

    assign in_ready    = !s_valid;
    assign out_payload = o_data;
    assign out_valid   = o_valid;

    // O refills from S first, then from the input; S only catches a beat while O is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            s_data  <= '0;
            s_valid <= 1'b0;
        end else if (!o_valid || out_ready) begin
            if (s_valid) begin
                o_data  <= s_data;
                o_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_valid) begin
                o_data  <= in_payload;
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (in_valid && !s_valid) begin
            s_data  <= in_payload;
            s_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_select_pipe.sv
// N-way operand selector with registered, skid-buffered valid/ready output.
// Select codes at or above NUM_IN yield zero data with sel_err set.
module operand_select_pipe
    import operand_select_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NUM_IN = DEF_NUM_IN
) (
    input logic                 clk,
    input logic                 reset,
    operand_select_pipe_if.slave bus
);

    localparam int unsigned SEL_W = clog2(NUM_IN);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel_err;
    } stage_beat_t;

    logic [WIDTH-1:0] src [NUM_IN];
    stage_beat_t      sel_beat;
    stage_beat_t      out_beat;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_src
        assign src[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

    // Pick the addressed source; anything unmatched falls through to the error beat
    always_comb begin
        sel_beat.data    = '0;
        sel_beat.sel_err = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_beat.data    = src[k];
                sel_beat.sel_err = 1'b0;
            end
        end
    end

    skid_buffer #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_payload  (sel_beat),
        .in_valid    (bus.in_valid),
        .in_ready    (bus.in_ready),
        .out_payload (out_beat),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready)
    );

    assign bus.out_data    = out_beat.data;
    assign bus.out_sel_err = out_beat.sel_err;

endmodule
